// File: rtl/xor_mismatch_counter.sv
// ---------------------------------------------------------------------------
// xor_mismatch_counter
//
// Purpose:
//   Downstream stage of the gate-level XOR comparator. Every 1 on y_in means
//   streams A and B disagreed on that bit. The inputs pass through a two-stage
//   register pipeline that absorbs gate-delay glitches. Mismatches are then
//   counted over frames of FRAME_LEN valid bits, and the block reports a
//   per-frame error count and a pass/fail flag.
//
// Parameters:
//   FRAME_LEN  valid bits per frame (1 .. 2**CNT_W-1)
//   CNT_W      width of err_count and of the internal bit index
//   ERR_LIMIT  early-abort error threshold (1 .. FRAME_LEN)
//
// Ports:
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous, active-high reset
//   y_in         in   1      XOR comparator output (1 = mismatch)
//   in_valid     in   1      y_in carries a frame bit this cycle
//   frame_start  in   1      one-cycle pulse that begins a new frame
//   busy         out  1      frame in progress
//   frame_done   out  1      one-cycle pulse: frame finished, results valid
//   frame_ok     out  1      last completed frame had zero mismatches
//   err_count    out  CNT_W  mismatches in the current or last frame
//
// Configuration macro:
//   XOR_EARLY_ABORT_EN  when defined, a frame ends as soon as its error
//                       count reaches ERR_LIMIT. When undefined, every frame
//                       runs the full FRAME_LEN bits and ERR_LIMIT is ignored.
// ---------------------------------------------------------------------------
module xor_mismatch_counter #(
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 5,
    parameter int ERR_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             y_in,
    input  logic             in_valid,
    input  logic             frame_start,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] LEN_C   = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(ERR_LIMIT);

`ifdef XOR_EARLY_ABORT_EN
    localparam bit EARLY_ABORT = 1'b1;
`else
    localparam bit EARLY_ABORT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_stage1;
    logic [2:0]       r_stage2;
    logic [CNT_W-1:0] r_bitIdx;
    logic [CNT_W-1:0] r_errCount;
    logic             r_busy;
    logic             r_done;
    logic             r_ok;

    logic             w_sStart;
    logic             w_sValid;
    logic             w_sY;
    logic             w_accept;
    logic [CNT_W-1:0] w_nextIdx;
    logic [CNT_W-1:0] w_nextErr;
    logic             w_frameEnd;

    // The inputs travel as one {frame_start, in_valid, y_in} bundle through
    // two registers, so all three stay aligned. The FSM only sees stage 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage1 <= '0;
            r_stage2 <= '0;
        end else begin
            r_stage1 <= {frame_start, in_valid, y_in};
            r_stage2 <= r_stage1;
        end
    end

    assign w_sStart = r_stage2[2];
    assign w_sValid = r_stage2[1];
    assign w_sY     = r_stage2[0];

    // A start restarts both counters from zero. A valid bit in the same cycle
    // is folded in as bit 0 of the new frame, which covers both a fresh start
    // and an abort-restart from COUNT. A frame ends on the bit that reaches
    // FRAME_LEN. With early abort, it also ends on the error that reaches
    // ERR_LIMIT.
    always_comb begin
        w_accept   = 1'b0;
        w_nextIdx  = (w_sStart ? '0 : r_bitIdx) + CNT_W'(w_sValid);
        w_nextErr  = (w_sStart ? '0 : r_errCount) + CNT_W'(w_sValid & w_sY);
        w_frameEnd = w_sValid &&
                     ((w_nextIdx == LEN_C) ||
                      (EARLY_ABORT && w_sY && (w_nextErr == LIMIT_C)));
        case (r_state)
            IDLE:    w_accept = w_sStart;
            COUNT:   w_accept = w_sStart || w_sValid;
            default: w_accept = 1'b0;
        endcase
    end

    // Frame FSM with registered outputs. DONE lasts exactly one cycle and
    // ignores any start. The err_count and frame_ok values hold through IDLE
    // until the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bitIdx   <= '0;
            r_errCount <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ok       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, COUNT: begin
                    if (w_accept) begin
                        r_bitIdx   <= w_nextIdx;
                        r_errCount <= w_nextErr;
                        if (w_frameEnd) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_ok    <= (w_nextErr == '0);
                        end else begin
                            r_state <= COUNT;
                            r_busy  <= 1'b1;
                            if (w_sStart) begin
                                r_ok <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign frame_done = r_done;
    assign frame_ok   = r_ok;
    assign err_count  = r_errCount;

endmodule
